// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and fixed commit latency.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled by defining MULDIV_MADD_EN.
module muldiv_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;
`ifdef MULDIV_MADD_EN
    localparam logic [3:0] OpMadd  = 4'd7;
    localparam logic [3:0] OpMaddu = 4'd8;
    localparam logic [3:0] OpMsub  = 4'd9;
    localparam logic [3:0] OpMsubu = 4'd10;
`endif

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic        load;
    logic        is_mul, is_div;

    always_comb begin
        is_mul = (op == OpMult) || (op == OpMultu);
`ifdef MULDIV_MADD_EN
        is_mul = is_mul || (op == OpMadd) || (op == OpMaddu) || (op == OpMsub) || (op == OpMsubu);
`endif
        is_div = (op == OpDiv) || (op == OpDivu);
    end

    logic [63:0] prod_s, prod_u, result;
    logic [31:0] quot, rem;
    logic        div_zero, commit_en;

    always_comb begin
        prod_s   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u   = {32'b0, a_q} * {32'b0, b_q};
        div_zero = (b_q == 32'd0);
        quot     = '0;
        rem      = '0;
        if (div_zero) begin
            quot = '0;
            rem  = '0;
        end else if (op_q == OpDiv) begin
            // Most-negative / -1 overflows; architecturally it yields the dividend.
            if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
                quot = 32'h8000_0000;
                rem  = '0;
            end else begin
                quot = 32'($signed(a_q) / $signed(b_q));
                rem  = 32'($signed(a_q) % $signed(b_q));
            end
        end else begin
            quot = a_q / b_q;
            rem  = a_q % b_q;
        end

        case (op_q)
            OpMult:         result = prod_s;
            OpMultu:        result = prod_u;
            OpDiv, OpDivu:  result = {rem, quot};
`ifdef MULDIV_MADD_EN
            // Accumulator is read at commit time, not at start.
            OpMadd:         result = {hi_q, lo_q} + prod_s;
            OpMaddu:        result = {hi_q, lo_q} + prod_u;
            OpMsub:         result = {hi_q, lo_q} - prod_s;
            OpMsubu:        result = {hi_q, lo_q} - prod_u;
`endif
            default:        result = {hi_q, lo_q};
        endcase
        commit_en = !(((op_q == OpDiv) || (op_q == OpDivu)) && div_zero);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (is_mul) begin
                        load    = 1'b1;
                        cnt_d   = 4'(MULT_CYCLES);
                        state_d = StRun;
                    end else if (is_div) begin
                        load    = 1'b1;
                        cnt_d   = 4'(DIV_CYCLES);
                        state_d = StRun;
                    end else if (op == OpMthi) begin
                        hi_d = in0;
                    end else if (op == OpMtlo) begin
                        lo_d = in0;
                    end
                end
            end
            StRun: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    if (commit_en) begin
                        hi_d = result[63:32];
                        lo_d = result[31:0];
                    end
                end
            end
        endcase
        busy_d = (state_d == StRun);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (load) begin
                op_q <= op;
                a_q  <= in0;
                b_q  <= in1;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: table-driven mul/div vectors plus
// hand-written sequences for MTHI/MTLO, ignored starts, reset and MADD ops.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] in0, in1;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi, m_lo;

    muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .in0     (in0),
        .in1     (in1),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cycles;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a start for one cycle from the current negedge; returns at the next negedge.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        in0   = a;
        in1   = b;
        @(negedge clk);
        start = 1'b0;
        op    = 4'd0;
    endtask

    task automatic wait_finish(input string name, input int already, input int exp_cycles,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cnt;
        bit held;
        cnt  = already;
        held = 1'b1;
        while (busy === 1'b1 && cnt < 64) begin
            if (hi !== m_hi || lo !== m_lo || done !== 1'b0) held = 1'b0;
            @(negedge clk);
            cnt++;
        end
        check({name, " busy cycles"}, 64'(cnt), 64'(exp_cycles));
        check({name, " hold during run"}, 64'(held), 64'd1);
        check({name, " done"}, 64'(done), 64'd1);
        check({name, " hi"}, 64'(hi), 64'(exp_hi));
        check({name, " lo"}, 64'(lo), 64'(exp_lo));
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    initial begin
        vecs[0] = '{4'd1, 32'hFFFF_FFFE, 32'd3,        5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{4'd3, 32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
        vecs[4] = '{4'd4, 32'd100,       32'd7,        10, 32'd2,         32'd14};
        vecs[5] = '{4'd3, 32'd7,         32'hFFFF_FFFE, 10, 32'd1,        32'hFFFF_FFFD};
        vecs[6] = '{4'd1, 32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'h0000_0000};
        vecs[7] = '{4'd2, 32'h8000_0000, 32'd2,        5,  32'd1,         32'd0};
        vecs[8] = '{4'd4, 32'hFFFF_FFFF, 32'd10,       10, 32'd5,         32'h1999_9999};

        reset_n = 1'b0;
        start   = 1'b0;
        op      = 4'd0;
        in0     = '0;
        in1     = '0;
        m_hi    = '0;
        m_lo    = '0;
        repeat (2) @(negedge clk);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_finish($sformatf("vec%0d", i), 0, vecs[i].cycles, vecs[i].e_hi, vecs[i].e_lo);
            @(negedge clk);
            check($sformatf("vec%0d done width", i), 64'(done), 64'd0);
        end

        // MTHI then divide-by-zero: HI/LO untouched, full latency still taken.
        issue(4'd5, 32'h1234_5678, 32'd0);
        check("mthi hi", 64'(hi), 64'h1234_5678);
        check("mthi busy", 64'(busy), 64'd0);
        check("mthi done", 64'(done), 64'd0);
        m_hi = 32'h1234_5678;
        issue(4'd4, 32'd5, 32'd0);
        wait_finish("divu by zero", 0, 10, m_hi, m_lo);

        // Start accepted in the done cycle.
        issue(4'd2, 32'd6, 32'd7);
        wait_finish("back to back", 0, 5, 32'd0, 32'd42);
        @(negedge clk);

        issue(4'd6, 32'h0000_0055, 32'd0);
        check("mtlo lo", 64'(lo), 64'h55);
        check("mtlo hi", 64'(hi), 64'd0);
        m_lo = 32'h55;

        // Starts during RUN are ignored.
        issue(4'd1, 32'd3, 32'd5);
        start = 1'b1;
        op    = 4'd6;
        in0   = 32'h0000_DEAD;
        @(negedge clk);
        op    = 4'd3;
        in0   = 32'd100;
        in1   = 32'd3;
        @(negedge clk);
        start = 1'b0;
        op    = 4'd0;
        wait_finish("ignored starts", 2, 5, 32'd0, 32'd15);
        @(negedge clk);

        // NONE, reserved ops and start=0 do nothing.
        begin
            logic [3:0] nop_ops[3];
            logic       nop_start[3];
            nop_ops   = '{4'd0, 4'd12, 4'd1};
            nop_start = '{1'b1, 1'b1, 1'b0};
            for (int i = 0; i < 3; i++) begin
                start = nop_start[i];
                op    = nop_ops[i];
                in0   = 32'hAAAA_AAAA;
                in1   = 32'h5555_5555;
                @(negedge clk);
                start = 1'b0;
                op    = 4'd0;
                @(negedge clk);
                check($sformatf("noop%0d busy", i), 64'(busy), 64'd0);
                check($sformatf("noop%0d hilo", i), {hi, lo}, {m_hi, m_lo});
            end
        end

        // Asynchronous reset during busy cycle 3.
        issue(4'd1, 32'd7, 32'd9);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrun reset hi", 64'(hi), 64'd0);
        check("midrun reset lo", 64'(lo), 64'd0);
        check("midrun reset busy", 64'(busy), 64'd0);
        check("midrun reset done", 64'(done), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        m_hi = '0;
        m_lo = '0;
        repeat (7) @(negedge clk);
        check("after reset idle busy", 64'(busy), 64'd0);
        check("after reset hilo", {hi, lo}, 64'd0);

        // MSUB: 10 - 3*4 = -2 when enabled; reserved otherwise.
        issue(4'd5, 32'd0, 32'd0);
        issue(4'd6, 32'd10, 32'd0);
        m_lo = 32'd10;
        check("pre-msub lo", 64'(lo), 64'd10);
        issue(4'd9, 32'd3, 32'd4);
`ifdef MULDIV_MADD_EN
        wait_finish("msub", 0, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
`else
        repeat (3) @(negedge clk);
        check("msub disabled busy", 64'(busy), 64'd0);
        check("msub disabled done", 64'(done), 64'd0);
        check("msub disabled hilo", {hi, lo}, {m_hi, m_lo});
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle multiply/divide unit with the HI/LO register pair. It sits beside the execute-stage ALU and receives the same forwarded rs/rt operands. It sequences MULT/MULTU/DIV/DIVU over a fixed latency and serves MTHI/MTLO writes. It exports `busy` and `done` so the hazard unit can stall MFHI/MFLO and any later mul/div op.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD-family ops when enabled); legal range 1..15
DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..15

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  issue the op on `op` this cycle (instruction is in E stage and valid)
op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11-15 reserved
in0  input  32  rs operand (forwarded)
in1  input  32  rt operand (forwarded)
busy  output  1  registered; high while a mul/div op is in flight
done  output  1  registered one-cycle pulse in the cycle new HI/LO from a mul/div op first become visible
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Asynchronous reset (reset_n=0): hi=0, lo=0, busy=0, done=0, counter=0, state IDLE. This applies immediately, including mid-operation; an in-flight op is discarded.
- State machine:
  - IDLE plus start with op MULT/MULTU: latch in0/in1 and op, load counter=MULT_CYCLES, go to RUN.
  - IDLE plus start with op DIV/DIVU: same, but counter=DIV_CYCLES.
- RUN state:
  - busy=1; decrement the counter each cycle.
  - On the edge where the counter goes from 1 to 0: commit the result to hi/lo, set busy=0 and done=1, return to IDLE.
- Timing:
  - busy rises the cycle after start and stays high for exactly N cycles.
  - hi/lo hold their old values throughout RUN.
  - The new values appear in the same cycle as the done pulse.
  - The hazard unit stalls on (start & mul/div op) | busy.
- Back-to-back: a start in the cycle where done=1 is accepted normally (state is IDLE).
- MTHI (op 5) with start in IDLE: hi <= in0 at the next edge; no busy, no done. MTLO (op 6) likewise writes lo.
- Any start while busy=1 is ignored: no state, counter, hi or lo change. The hazard unit guarantees this never happens; the bench checks it is harmless.
- op NONE, reserved op, or start=0: no effect.
- Arithmetic, using operands latched at start:
  - MULT: {hi,lo} = signed 64-bit product.
  - MULTU: {hi,lo} = unsigned 64-bit product.
  - DIV: lo = signed quotient truncated toward zero; hi = remainder, carrying the sign of the dividend.
  - DIVU: lo = unsigned quotient; hi = unsigned remainder.
- Division boundary cases:
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
  - Divide by zero (DIV or DIVU): full busy period and done pulse still occur, but hi and lo are left unchanged.
- Result computation may be combinational on the latched operands. Only the commit timing is architectural.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- When defined, ops 7-10 run for MULT_CYCLES with {hi,lo} at commit computed as:
  - MADD: {hi,lo} + signed(in0*in1).
  - MADDU: {hi,lo} + unsigned(in0*in1).
  - MSUB: {hi,lo} - signed(in0*in1).
  - MSUBU: {hi,lo} - unsigned(in0*in1).
  - All results wrap modulo 2^64.
  - The accumulated {hi,lo} is sampled at commit, not at start.
- When undefined, ops 7-10 are treated as reserved (no effect, busy stays 0).

Test Plan:
- Reset, then start MULT in0=0xFFFFFFFE (-2), in1=3 -> busy high for 5 cycles starting the cycle after start; hi/lo stay 0 until done; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses 1 cycle.
- MULTU in0=0xFFFFFFFF, in1=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
- DIV in0=0xFFFFFFF9 (-7), in1=2 -> 10 busy cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x12345678 then DIVU in0=5, in1=0 -> hi=0x12345678 the cycle after MTHI with busy=0; the DIVU runs 10 busy cycles, pulses done, and leaves hi=0x12345678, lo unchanged.
- MULT busy; start MTLO 0xDEAD and start DIV mid-run -> both ignored, busy ends at cycle 5 with the MULT result. Assert reset_n=0 at busy cycle 3 of a second MULT -> hi=lo=0, busy=0 immediately.
- With MULDIV_MADD_EN: MTHI 0, MTLO 10, then MSUB in0=3, in1=4 -> hi=0, lo=0xFFFFFFFE... no: {hi,lo} = 10 - 12 = -2, so hi=0xFFFFFFFF, lo=0xFFFFFFFE. Without the macro the same op 9 leaves busy=0 and hi/lo unchanged.
